// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
//
// Watches the AN/SEG lines of a two-digit multiplexed 7-segment display. Both
// buses are synchronised, then debounced: a pattern is captured once after it
// has been seen for STABLE_CYCLES consecutive samples. Captured patterns are
// decoded into digits. A units digit (AN=11111110) and a tens digit
// (AN=11111101) together form a frame. Each completed frame updates the
// outputs and produces a one-cycle VALID pulse.
//
// Optional feature: define SEGDEC_DASH_EN to accept SEG=1111110 as a dash.
// The dash has digit code 4'hA. Any frame that contains a dash reports
// VALUE=7'h7F. Without the macro, that pattern is undecodable like any other.
//
// Parameters
//   STABLE_CYCLES  identical consecutive samples needed for a capture (2..255)
// Ports
//   CLK100MHZ  in   system clock, rising edge
//   RST        in   asynchronous active-high reset
//   AN[7:0]    in   active-low digit enables of the observed display
//   SEG[6:0]   in   active-low segments, bit6=a .. bit0=g
//   DIG0[3:0]  out  units digit code of the last completed frame
//   DIG1[3:0]  out  tens digit code of the last completed frame
//   VALUE[6:0] out  DIG1*10+DIG0 of the last completed frame
//   VALID      out  one-cycle pulse per completed frame
//   ERR_CNT    out  saturating count of undecodable patterns
// -----------------------------------------------------------------------------
module seg_scan_decoder #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic       CLK100MHZ,
    input  logic       RST,
    input  logic [7:0] AN,
    input  logic [6:0] SEG,
    output logic [3:0] DIG0,
    output logic [3:0] DIG1,
    output logic [6:0] VALUE,
    output logic       VALID,
    output logic [7:0] ERR_CNT
);

    localparam logic [7:0] CAPTURE_AT = 8'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {EMPTY, HAVE0, HAVE1} state_t;

    // Returns {decodable, digit_code}.
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        case (s)
            7'b0000001: decode_seg = 5'b1_0000;
            7'b1001111: decode_seg = 5'b1_0001;
            7'b0010010: decode_seg = 5'b1_0010;
            7'b0000110: decode_seg = 5'b1_0011;
            7'b1001100: decode_seg = 5'b1_0100;
            7'b0100100: decode_seg = 5'b1_0101;
            7'b0100000: decode_seg = 5'b1_0110;
            7'b0001111: decode_seg = 5'b1_0111;
            7'b0000000: decode_seg = 5'b1_1000;
            7'b0000100: decode_seg = 5'b1_1001;
`ifdef SEGDEC_DASH_EN
            7'b1111110: decode_seg = 5'b1_1010;
`endif
            default:    decode_seg = 5'b0_0000;
        endcase
    endfunction

    function automatic logic [6:0] frame_value(input logic [3:0] tens, input logic [3:0] units);
`ifdef SEGDEC_DASH_EN
        if (tens == 4'hA || units == 4'hA) begin
            return 7'h7F;
        end
`endif
        // Both digits are 0..9 here, so the result is at most 99 and fits in 7 bits.
        return 7'(tens) * 7'd10 + 7'(units);
    endfunction

    logic [7:0] an_meta_reg, an_sample_reg, an_prev_reg;
    logic [6:0] seg_meta_reg, seg_sample_reg, seg_prev_reg;
    logic [7:0] stable_cnt_reg, stable_cnt_next;
    state_t     state_reg, state_next;
    logic [3:0] units_reg, units_next, tens_reg, tens_next;
    logic [3:0] dig0_reg, dig0_next, dig1_reg, dig1_next;
    logic [6:0] value_reg, value_next;
    logic       valid_reg, valid_next;
    logic [7:0] err_reg, err_next;

    logic       capture, is_units, is_tens, dec_ok;
    logic [3:0] dec_code;

    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            an_meta_reg    <= 8'hFF;
            an_sample_reg  <= 8'hFF;
            an_prev_reg    <= 8'hFF;
            seg_meta_reg   <= 7'h7F;
            seg_sample_reg <= 7'h7F;
            seg_prev_reg   <= 7'h7F;
            stable_cnt_reg <= 8'd0;
            state_reg      <= EMPTY;
            units_reg      <= 4'd0;
            tens_reg       <= 4'd0;
            dig0_reg       <= 4'd0;
            dig1_reg       <= 4'd0;
            value_reg      <= 7'd0;
            valid_reg      <= 1'b0;
            err_reg        <= 8'd0;
        end else begin
            an_meta_reg    <= AN;
            an_sample_reg  <= an_meta_reg;
            an_prev_reg    <= an_sample_reg;
            seg_meta_reg   <= SEG;
            seg_sample_reg <= seg_meta_reg;
            seg_prev_reg   <= seg_sample_reg;
            stable_cnt_reg <= stable_cnt_next;
            state_reg      <= state_next;
            units_reg      <= units_next;
            tens_reg       <= tens_next;
            dig0_reg       <= dig0_next;
            dig1_reg       <= dig1_next;
            value_reg      <= value_next;
            valid_reg      <= valid_next;
            err_reg        <= err_next;
        end
    end

    // The counter gives the number of consecutive equal sample pairs.
    // When it equals STABLE_CYCLES-1, the previous-sample register has held
    // the same value for STABLE_CYCLES samples. The counter then moves past
    // that value or saturates, so only one capture occurs per stable interval.
    always_comb begin
        stable_cnt_next = stable_cnt_reg;
        if (an_sample_reg != an_prev_reg || seg_sample_reg != seg_prev_reg) begin
            stable_cnt_next = 8'd0;
        end else if (stable_cnt_reg != 8'hFF) begin
            stable_cnt_next = stable_cnt_reg + 8'd1;
        end
    end

    assign capture            = (stable_cnt_reg == CAPTURE_AT);
    assign is_units           = (an_prev_reg == 8'hFE);
    assign is_tens            = (an_prev_reg == 8'hFD);
    assign {dec_ok, dec_code} = decode_seg(seg_prev_reg);

    always_comb begin
        state_next = state_reg;
        units_next = units_reg;
        tens_next  = tens_reg;
        dig0_next  = dig0_reg;
        dig1_next  = dig1_reg;
        value_next = value_reg;
        valid_next = 1'b0;
        err_next   = err_reg;
        if (capture && (is_units || is_tens)) begin
            if (!dec_ok) begin
                if (err_reg != 8'hFF) begin
                    err_next = err_reg + 8'd1;
                end
                state_next = EMPTY;
            end else if (is_units) begin
                if (state_reg == HAVE1) begin
                    dig0_next  = dec_code;
                    dig1_next  = tens_reg;
                    value_next = frame_value(tens_reg, dec_code);
                    valid_next = 1'b1;
                    state_next = EMPTY;
                end else begin
                    units_next = dec_code;
                    state_next = HAVE0;
                end
            end else begin
                if (state_reg == HAVE0) begin
                    dig0_next  = units_reg;
                    dig1_next  = dec_code;
                    value_next = frame_value(dec_code, units_reg);
                    valid_next = 1'b1;
                    state_next = EMPTY;
                end else begin
                    tens_next  = dec_code;
                    state_next = HAVE1;
                end
            end
        end
    end

    assign DIG0    = dig0_reg;
    assign DIG1    = dig1_reg;
    assign VALUE   = value_reg;
    assign VALID   = valid_reg;
    assign ERR_CNT = err_reg;

endmodule
